sw_lane_port: RTL and testbench

SW_LANE_PORT -- requirements
Module: sw_lane_port

---
 rtl/sw_lane_port.sv | 183 ++++++++++++++++++
 tb/tb_sw_lane_port.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_lane_port.sv
// sw_lane_port: ingress word FIFO that steers each word to one of two
// egress lanes. The lane is chosen by bit ROUTE_BIT of the word at the head
// of the FIFO. Words leave in FIFO order across both lanes.
//
// Optional feature macro: SW_LANE_PORT_STATS_EN
//   When it is defined, fwd_cnt_0/1 count the cycles with a valid on each lane.
//   When it is not defined, both outputs are tied to zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset; ingress pushes are accepted, nothing is forwarded
// FLUSH | one cycle; pointers, occupancy, valids, ovf and counters cleared
// RUN   | forwarding; pops whenever data is present and bp_q is low
module sw_lane_port #(
  parameter int DEPTH     = 16,
  parameter int FULL_TH   = 12,
  parameter int ROUTE_BIT = 2
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  input  logic        sw_ivld,
  input  logic [31:0] sw_idata,
  output logic        sw_ofw,
  output logic        sw_ovld_0,
  output logic        sw_ovld_1,
  output logic [31:0] sw_odata_0,
  output logic [31:0] sw_odata_1,
  input  logic        sw_bp,
  output logic        busy,
  output logic        ovf,
  output logic [31:0] fwd_cnt_0,
  output logic [31:0] fwd_cnt_1
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            flush;
  logic            run;

  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [OW-1:0]   occ;
  logic            bp_q;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            drop_ovf;
  logic [31:0]     head;
  logic            head_lane;

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and state decodes
  always_comb begin
    state_nxt = state;
    flush     = 1'b0;
    run       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ap_start) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush     = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        run = 1'b1;
        if (ap_start) state_nxt = ST_FLUSH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The full check uses the occupancy at the start of the cycle. A pop in the
  // same cycle does not make room for a word that arrives while the FIFO is full.
  assign full      = (occ == OW'(DEPTH));
  assign empty     = (occ == '0);
  assign push      = sw_ivld & ~full & ~flush;
  assign drop_ovf  = sw_ivld &  full & ~flush;
  assign pop       = run & ~empty & ~bp_q;
  assign head      = mem[rd_ptr];
  assign head_lane = head[ROUTE_BIT];

  // FIFO storage. Contents are not reset; occupancy alone defines which entries are live.
  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= sw_idata;
  end

  // Pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ap_clk) begin
    if (ap_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Backpressure is registered once. This leaves room for one or two words in flight.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) bp_q <= 1'b0;
    else        bp_q <= sw_bp;
  end

  // Almost-full flag, registered from the current occupancy
  always_ff @(posedge ap_clk) begin
    if (ap_rst) sw_ofw <= 1'b0;
    else        sw_ofw <= (occ >= OW'(FULL_TH));
  end

  // Egress registers. The data on each lane holds while its valid is low.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sw_ovld_0  <= 1'b0;
      sw_ovld_1  <= 1'b0;
      sw_odata_0 <= '0;
      sw_odata_1 <= '0;
    end else if (flush) begin
      sw_ovld_0  <= 1'b0;
      sw_ovld_1  <= 1'b0;
    end else begin
      sw_ovld_0 <= pop & ~head_lane;
      sw_ovld_1 <= pop &  head_lane;
      if (pop && !head_lane) sw_odata_0 <= head;
      if (pop &&  head_lane) sw_odata_1 <= head;
    end
  end

  // Sticky overflow flag, cleared only by reset or FLUSH
  always_ff @(posedge ap_clk) begin
    if (ap_rst || flush) ovf <= 1'b0;
    else if (drop_ovf)   ovf <= 1'b1;
  end

  assign busy = run & (~empty | sw_ovld_0 | sw_ovld_1);

`ifdef SW_LANE_PORT_STATS_EN
  logic [31:0] cnt_0;
  logic [31:0] cnt_1;

  // Per-lane forwarded-word counters. They wrap at 2^32.
  always_ff @(posedge ap_clk) begin
    if (ap_rst || flush) begin
      cnt_0 <= '0;
      cnt_1 <= '0;
    end else begin
      if (sw_ovld_0) cnt_0 <= cnt_0 + 32'd1;
      if (sw_ovld_1) cnt_1 <= cnt_1 + 32'd1;
    end
  end

  assign fwd_cnt_0 = cnt_0;
  assign fwd_cnt_1 = cnt_1;
`else
  assign fwd_cnt_0 = '0;
  assign fwd_cnt_1 = '0;
`endif

endmodule

// File: tb/tb_sw_lane_port.sv
// Directed bench for sw_lane_port with its default parameters
// (DEPTH=16, FULL_TH=12, ROUTE_BIT=2).
module tb_sw_lane_port;

  logic        clk;
  logic        ap_rst;
  logic        ap_start;
  logic        sw_ivld;
  logic [31:0] sw_idata;
  logic        sw_ofw;
  logic        sw_ovld_0;
  logic        sw_ovld_1;
  logic [31:0] sw_odata_0;
  logic [31:0] sw_odata_1;
  logic        sw_bp;
  logic        busy;
  logic        ovf;
  logic [31:0] fwd_cnt_0;
  logic [31:0] fwd_cnt_1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] d;
    logic        lane;
    int          cyc;
  } ev_t;
  ev_t mon[$];

  sw_lane_port dut (
    .ap_clk     (clk),
    .ap_rst     (ap_rst),
    .ap_start   (ap_start),
    .sw_ivld    (sw_ivld),
    .sw_idata   (sw_idata),
    .sw_ofw     (sw_ofw),
    .sw_ovld_0  (sw_ovld_0),
    .sw_ovld_1  (sw_ovld_1),
    .sw_odata_0 (sw_odata_0),
    .sw_odata_1 (sw_odata_1),
    .sw_bp      (sw_bp),
    .busy       (busy),
    .ovf        (ovf),
    .fwd_cnt_0  (fwd_cnt_0),
    .fwd_cnt_1  (fwd_cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Egress monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (sw_ovld_0) mon.push_back('{sw_odata_0, 1'b0, cyc});
    if (sw_ovld_1) mon.push_back('{sw_odata_1, 1'b1, cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    sw_ivld  = 1'b1;
    sw_idata = d;
    tick();
    sw_ivld  = 1'b0;
  endtask

  function automatic logic [31:0] w(input int i);
    return 32'h0000_1000 + i;
  endfunction

  function automatic logic [31:0] b(input int i);
    return 32'h0000_2000 + 4 * i;
  endfunction

  initial begin
    logic [31:0] e;
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    sw_ivld  = 1'b0;
    sw_idata = '0;
    sw_bp    = 1'b0;
    ticks(3);

    // Reset state
    check("rst_ofw",    {31'd0, sw_ofw},    32'd0);
    check("rst_ovld0",  {31'd0, sw_ovld_0}, 32'd0);
    check("rst_ovld1",  {31'd0, sw_ovld_1}, 32'd0);
    check("rst_busy",   {31'd0, busy},      32'd0);
    check("rst_ovf",    {31'd0, ovf},       32'd0);
    check("rst_odata0", sw_odata_0,         32'd0);
    check("rst_odata1", sw_odata_1,         32'd0);
    check("rst_cnt0",   fwd_cnt_0,          32'd0);
    check("rst_cnt1",   fwd_cnt_1,          32'd0);
    ap_rst = 1'b0;
    tick();

    // Start, then push 0x4 (lane 1) and 0x0 (lane 0). Each egress valid comes 2 cycles after its push.
    ap_start = 1'b1; tick();
    ap_start = 1'b0; tick();
    sw_ivld = 1'b1; sw_idata = 32'h4; tick();
    sw_idata = 32'h0; tick();
    sw_ivld = 1'b0;
    check("lat_ovld1",  {31'd0, sw_ovld_1}, 32'd1);
    check("lat_ovld0a", {31'd0, sw_ovld_0}, 32'd0);
    check("lat_odata1", sw_odata_1,         32'h4);
    check("lat_busy",   {31'd0, busy},      32'd1);
    tick();
    check("nxt_ovld0",  {31'd0, sw_ovld_0}, 32'd1);
    check("nxt_ovld1",  {31'd0, sw_ovld_1}, 32'd0);
    check("nxt_odata0", sw_odata_0,         32'h0);
    check("hold_odata1", sw_odata_1,        32'h4);
    tick();
    check("drain_ovld0", {31'd0, sw_ovld_0}, 32'd0);
    check("drain_busy",  {31'd0, busy},      32'd0);
`ifdef SW_LANE_PORT_STATS_EN
    check("cnt0_after2", fwd_cnt_0, 32'd1);
    check("cnt1_after2", fwd_cnt_1, 32'd1);
`else
    check("cnt0_tied", fwd_cnt_0, 32'd0);
    check("cnt1_tied", fwd_cnt_1, 32'd0);
`endif

    // Hold backpressure and push 12 words. sw_ofw must follow the occupancy.
    mon.delete();
    sw_bp = 1'b1; tick();
    for (int i = 0; i < 11; i++) push(w(i));
    ticks(2);
    check("ofw_at11", {31'd0, sw_ofw}, 32'd0);
    push(w(11));
    ticks(2);
    check("ofw_at12",    {31'd0, sw_ofw}, 32'd1);
    check("bp_no_egress", mon.size(),     32'd0);
    check("bp_busy",     {31'd0, busy},   32'd1);

    // Fill to DEPTH. The 17th push is dropped and sets ovf.
    for (int i = 12; i < 16; i++) push(w(i));
    check("ovf_at16", {31'd0, ovf}, 32'd0);
    push(w(16));
    check("ovf_at17", {31'd0, ovf}, 32'd1);
    mon.delete();
    sw_bp = 1'b0;
    ticks(25);
    check("drain_count", mon.size(), 32'd16);
    for (int i = 0; i < 16 && i < mon.size(); i++) begin
      e = w(i);
      check($sformatf("drain_data%0d", i), mon[i].d, e);
      check($sformatf("drain_lane%0d", i), {31'd0, mon[i].lane}, {31'd0, e[2]});
    end
    if (mon.size() == 16)
      check("drain_rate", mon[15].cyc - mon[0].cyc, 32'd15);
    check("ovf_sticky", {31'd0, ovf},    32'd1);
    check("drain_ofw",  {31'd0, sw_ofw}, 32'd0);
    check("idle_busy",  {31'd0, busy},   32'd0);

    // A FLUSH clears ovf.
    ap_start = 1'b1; tick();
    ap_start = 1'b0; tick();
    check("flush_ovf", {31'd0, ovf}, 32'd0);

    // Push and pop in the same cycle at occupancy 5
    sw_bp = 1'b1; tick();
    for (int i = 0; i < 5; i++) push(b(i));
    mon.delete();
    sw_bp = 1'b0; tick();
    sw_bp = 1'b1; push(b(5));
    ticks(3);
    check("pp_one_out", mon.size(), 32'd1);
    sw_bp = 1'b0;
    ticks(10);
    check("pp_total", mon.size(), 32'd6);
    for (int i = 0; i < 6 && i < mon.size(); i++)
      check($sformatf("pp_data%0d", i), mon[i].d, b(i));

    // ap_start in RUN with 6 words buffered. A word offered during FLUSH is dropped.
    sw_bp = 1'b1; tick();
    for (int i = 0; i < 6; i++) push(32'h0000_3000 + i);
    mon.delete();
    sw_bp = 1'b0; ap_start = 1'b1; tick();
    ap_start = 1'b0;
    check("fl_ovld0", {31'd0, sw_ovld_0}, 32'd0);
    check("fl_ovld1", {31'd0, sw_ovld_1}, 32'd0);
    sw_ivld = 1'b1; sw_idata = 32'hDEAD_BEEF; tick();
    sw_ivld = 1'b0;
    check("fl_ovf",  {31'd0, ovf},  32'd0);
    check("fl_busy", {31'd0, busy}, 32'd0);
    check("fl_cnt0", fwd_cnt_0, 32'd0);
    check("fl_cnt1", fwd_cnt_1, 32'd0);
    ticks(6);
    check("fl_no_egress", mon.size(),   32'd0);
    check("fl_ovf_late",  {31'd0, ovf}, 32'd0);

    // Reset in the middle of a transfer discards the buffered words.
    sw_bp = 1'b1; tick();
    for (int i = 0; i < 3; i++) push(32'h0000_4004 + i);
    sw_bp = 1'b0; tick();
    mon.delete();
    ap_rst = 1'b1; tick();
    check("mr_ovld0",  {31'd0, sw_ovld_0}, 32'd0);
    check("mr_ovld1",  {31'd0, sw_ovld_1}, 32'd0);
    check("mr_odata0", sw_odata_0, 32'd0);
    check("mr_odata1", sw_odata_1, 32'd0);
    check("mr_count",  mon.size(), 32'd0);
    ap_rst = 1'b0; tick();
    ap_start = 1'b1; tick();
    ap_start = 1'b0;
    ticks(6);
    check("mr_discard", mon.size(), 32'd0);

    // IDLE accepts pushes (seen through sw_ofw) but never forwards them.
    ap_rst = 1'b1; tick();
    ap_rst = 1'b0; tick();
    mon.delete();
    for (int i = 0; i < 12; i++) push(w(i));
    ticks(2);
    check("idle_ofw",     {31'd0, sw_ofw}, 32'd1);
    check("idle_busy2",   {31'd0, busy},   32'd0);
    check("idle_no_fwd",  mon.size(),      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
